// File: rtl/ram_port_ctrl_pkg.sv
// rtl/ram_port_ctrl_pkg.sv - shared types and helpers for the RAM port controller
package ram_port_ctrl_pkg;

  // INIT sweeps the RAM to a known value; RUN serves requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

  // Address width for a given number of entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// rtl/ram_init_sweep.sv - post-reset address sweep counter (built only with RAM_PORT_CTRL_INIT_EN)
`ifdef RAM_PORT_CTRL_INIT_EN
module ram_init_sweep
  import ram_port_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] count,
  output logic          last,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Walk addresses 0..DEPTH-1 once; the counter parks on the last address
  // so it can never wrap and rewrite entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (!done) begin
      if (count == LAST_ADDR) begin
        done <= 1'b1;
      end else begin
        count <= count + AW'(1);
      end
    end
  end

  // High on the cycle that writes the final entry.
  assign last = !done && (count == LAST_ADDR);

endmodule
`endif

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - request/response front end for a single-port sync RAM (option: RAM_PORT_CTRL_INIT_EN)
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int unsigned     SIZE       = 8,
  parameter int unsigned     DEPTH      = 16,
  parameter logic [SIZE-1:0] INIT_VALUE = '0,
  parameter int unsigned     AW         = addr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [SIZE-1:0] rsp_data,
  output logic            init_done,
  output logic [AW-1:0]   ram_address,
  output logic [SIZE-1:0] ram_write_data,
  output logic            ram_write_en,
  input  logic [SIZE-1:0] ram_read_data
);

  logic          in_init;
  logic [AW-1:0] sweep_addr;
  logic          pending_q;
  logic          stall;
  logic          ready_c;
  logic          accept;

`ifdef RAM_PORT_CTRL_INIT_EN
  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        sweep_last;
  logic        sweep_done;

  ram_init_sweep #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .count (sweep_addr),
    .last  (sweep_last),
    .done  (sweep_done)
  );

  // State register: reset always restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave INIT once the last entry has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign in_init   = (state_q == ST_INIT);
  assign init_done = sweep_done;
`else
  logic run_q;

  // Without a sweep the controller is ready from the first edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign in_init    = 1'b0;
  assign sweep_addr = '0;
  assign init_done  = run_q;
`endif

  // A held response or an in-flight read blocks new requests, so requests
  // complete strictly in acceptance order.
  assign stall     = rsp_valid && !rsp_ready;
  assign ready_c   = !in_init && !pending_q && !stall;
  assign accept    = req_valid && ready_c;
  assign req_ready = ready_c;

  // RAM port mux: sweep owns the port during INIT, requester otherwise.
  always_comb begin
    ram_address    = req_addr;
    ram_write_data = req_wdata;
    ram_write_en   = 1'b0;
    if (in_init) begin
      ram_address    = sweep_addr;
      ram_write_data = INIT_VALUE;
      ram_write_en   = 1'b1;
    end else begin
      ram_write_en   = accept && req_we;
    end
  end

  // Read pipeline: one cycle waiting on the RAM, then a held response slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      pending_q <= accept && !req_we;
      if (pending_q) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ram_read_data;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb/tb_ram_port_ctrl.sv - directed self-checking bench for ram_port_ctrl (sweep checks under RAM_PORT_CTRL_INIT_EN)
module tb_ram_port_ctrl;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [SIZE-1:0] INIT_V = 8'h5A;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [SIZE-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [SIZE-1:0] rsp_data;
  logic            init_done;
  logic [AW-1:0]   ram_address;
  logic [SIZE-1:0] ram_write_data;
  logic            ram_write_en;
  logic [SIZE-1:0] ram_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_ctrl #(
    .SIZE       (SIZE),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .init_done      (init_done),
    .ram_address    (ram_address),
    .ram_write_data (ram_write_data),
    .ram_write_en   (ram_write_en),
    .ram_read_data  (ram_read_data)
  );

  // Single-port synchronous RAM with one-cycle read latency.
  logic [SIZE-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; request accepted at the following posedge.
  task automatic do_write(input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    check("wr_ready", req_ready, 1);
    check("wr_en", ram_write_en, 1);
    check("wr_addr", ram_address, a);
    check("wr_data", ram_write_data, d);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [SIZE-1:0] d, input bit chk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    #1;
    check("rd_ready", req_ready, 1);
    check("rd_no_we", ram_write_en, 0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rd_pending_valid", rsp_valid, 0);
    check("rd_pending_ready", req_ready, 0);
    @(negedge clk);
    #1;
    check("rd_rsp_valid", rsp_valid, 1);
    if (chk) check("rd_rsp_data", rsp_data, d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_init_done", init_done, 0);
    rst = 1'b0;
    #1;
`ifdef RAM_PORT_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      check("sweep_we", ram_write_en, 1);
      check("sweep_addr", ram_address, i);
      check("sweep_data", ram_write_data, INIT_V);
      check("sweep_ready", req_ready, 0);
      check("sweep_not_done", init_done, 0);
      @(negedge clk);
      #1;
    end
    check("sweep_done", init_done, 1);
    check("sweep_stops", ram_write_en, 0);
    check("run_ready", req_ready, 1);
    do_read(4'd9, INIT_V, 1'b1);
`else
    check("noinit_we", ram_write_en, 0);
    check("noinit_done_pre", init_done, 0);
    @(negedge clk);
    #1;
    check("noinit_done", init_done, 1);
    do_read(4'd9, 8'h00, 1'b0);
`endif
    // Write then read the same address on the next cycle.
    do_write(4'd3, 8'hA5);
    do_read(4'd3, 8'hA5, 1'b1);
    do_write(4'd15, 8'h3C);
    do_read(4'd15, 8'h3C, 1'b1);
    @(negedge clk);

    // Hold the response under backpressure; a write attempt must not land.
    rsp_ready = 1'b0;
    do_read(4'd3, 8'hA5, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, 8'hA5);
      check("stall_ready", req_ready, 0);
      check("stall_no_we", ram_write_en, 0);
    end
    // Release: handshake and new read accepted in the same cycle.
    req_we = 1'b0; req_addr = 4'd15; rsp_ready = 1'b1;
    #1;
    check("release_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("release_cleared", rsp_valid, 0);
    @(negedge clk);
    #1;
    check("release_rsp_valid", rsp_valid, 1);
    check("release_rsp_data", rsp_data, 8'h3C);
    do_read(4'd3, 8'hA5, 1'b1);

    // Sustained reads: one accept every two cycles.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sustain_ready", req_ready, 32'((i % 2) == 0));
      @(negedge clk);
    end
    req_valid = 1'b0;
    #1;

    // Back-to-back writes, one per cycle.
    do_write(4'd5, 8'h11);
    do_write(4'd6, 8'h22);
    do_read(4'd5, 8'h11, 1'b1);
    do_read(4'd6, 8'h22, 1'b1);
    @(negedge clk);

    // Reset with a read pending discards the response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstpend_valid", rsp_valid, 0);
    check("rstpend_done", init_done, 0);
    rst = 1'b0;
    #1;
`ifdef RAM_PORT_CTRL_INIT_EN
    // Interrupt the sweep at address 7, it must restart from 0.
    repeat (7) @(negedge clk);
    #1;
    check("mid_addr7", ram_address, 7);
    check("mid_valid", rsp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      check("resweep_addr", ram_address, i);
      check("resweep_done", init_done, 0);
      check("resweep_valid", rsp_valid, 0);
      @(negedge clk);
      #1;
    end
    check("resweep_final_done", init_done, 1);
    check("resweep_no_we", ram_write_en, 0);
    do_read(4'd15, INIT_V, 1'b1);
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rstpend_quiet", rsp_valid, 0);
      check("rstpend_no_we", ram_write_en, 0);
    end
    check("rstpend_done_again", init_done, 1);
    do_read(4'd6, 8'h22, 1'b1);
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
